instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 Parameter FIFO_DEPTH, default 4, buffer entries; the value SHALL be a power of 2 and at least 2.
REQ-003 Port clk  in  1  single clock; all state SHALL update on the rising edge only.
REQ-004 Port rst  in  1  reset, synchronous and active-high.
REQ-005 Port start  in  1  one-cycle pulse that opens a program load at base_addr.
REQ-006 Port base_addr  in  ADDR_W  first imem write address, sampled on start.
REQ-007 Port finish  in  1  one-cycle pulse that closes the program after the FIFO drains.
REQ-008 Ports in_valid (in, 1) and in_ready (out, 1) SHALL form the instruction-input handshake.
REQ-009 Ports mnem (in, 4), rd/rn/rm (in, 4 each) and imm (in, 12, signed) SHALL carry one instruction.
REQ-010 Ports imem_we (out, 1), imem_addr (out, ADDR_W), imem_wdata (out, 32) and imem_ready (in, 1) SHALL form the memory-write port.
REQ-011 Ports busy, done, ovf, err_illegal and err_range (out, 1 each) and count (out, ADDR_W+1, words written) SHALL report status.

Function
REQ-012 The mnemonic-to-opcode map SHALL be: 0 MUL->0000, 1 DIV->0001, 2 LDR->0010, 3 STR->0011, 4 ADD->0100, 5 ADDI->0110, 6 B->1000, 7 BEQ->1001; values 8-15 are illegal.
REQ-013 The word layout SHALL be: [31:28] opcode, [27:24] rd, [23:20] rn, [19:16] rm, [15:12] zero, [11:0] immediate field.
REQ-014 Field rules SHALL be:
- MUL/DIV/ADD/BEQ: immediate field = 0.
- LDR/STR: rm = 0; immediate field = imm[11:0].
- ADDI: rm = 0; immediate field = sign-extension of imm[7:0].
- B: rd = rn = rm = 0; immediate field = sign-extension of imm[7:0].
REQ-015 A transfer (in_valid && in_ready) SHALL encode the instruction and push it into the FIFO on that same edge.
REQ-016 in_ready SHALL be 1 only in LOAD with the FIFO not full; there is no full-FIFO bypass even when a pop occurs in the same cycle.
REQ-017 An illegal mnemonic SHALL be consumed, not pushed, and SHALL set sticky err_illegal on the accepting edge.
REQ-018 imem_we SHALL be 1 whenever the FIFO is non-empty in LOAD or DRAIN, with imem_wdata = FIFO head and imem_addr = write pointer.
REQ-019 A write SHALL complete on an edge with imem_we && imem_ready; that edge pops the FIFO, increments the address and increments count.
REQ-020 imem_addr and imem_wdata SHALL stay stable while imem_we && !imem_ready.
REQ-021 Latency: a word accepted at edge N into an empty FIFO SHALL be presented with imem_we=1 in cycle N+1.
REQ-022 The state machine SHALL have states IDLE, LOAD, DRAIN and DONE.
REQ-023 Transitions SHALL be:
- IDLE or DONE + start -> LOAD.
- LOAD + finish -> DRAIN.
- DRAIN with FIFO empty -> DONE.
REQ-024 start in LOAD/DRAIN SHALL be ignored; finish outside LOAD SHALL be ignored; start and finish together in IDLE/DONE: start wins.
REQ-025 start SHALL flush the FIFO, load the pointer from base_addr, and clear count, ovf, err_illegal and err_range.
REQ-026 There SHALL be no wrap-around: a completed write to address all-ones SHALL move the block to DONE, discard remaining FIFO entries and set sticky ovf.
REQ-027 busy SHALL equal (state is LOAD or DRAIN); done SHALL equal (state is DONE).

Reset
REQ-028 On rst, the state SHALL go to IDLE, the FIFO SHALL empty, and imem_we, imem_addr, imem_wdata, count, in_ready, busy, done, ovf, err_illegal and err_range SHALL all be 0.
REQ-029 rst asserted mid-write SHALL abandon the write; imem_we SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-030 With ENC_RANGE_CHECK_EN defined, an ADDI or B instruction whose imm[11:7] bits are not all equal SHALL be consumed, not pushed, and SHALL set sticky err_range; LDR/STR accept the full 12-bit range.
REQ-031 Without ENC_RANGE_CHECK_EN, imm[11:8] SHALL be ignored for ADDI and B, and err_range SHALL be tied to 0.

Verification
REQ-032 rst; start with base_addr=0x10; ADD rd=1 rn=2 rm=3 -> next cycle imem_we=1, addr 0x10, data 0x41230000; count=1.
REQ-033 ADDI rd=4 rn=4 imm=0xFFE -> data 0x64400FFE; then imm=0x080 -> with macro: no write, err_range=1; without macro: data 0x64400F80.
REQ-034 imem_ready=0 while 6 instructions are offered -> in_ready=0 after 4 accepts, addr/data held; imem_ready=1 -> 4 writes on 4 consecutive cycles, then the remaining 2 are accepted.
REQ-035 mnem=0xA then LDR rd=1 rn=0 imm=0x123 -> err_illegal=1 and a single write with data 0x21000123.
REQ-036 ADDR_W=8, base_addr=0xFE, 3 instructions -> writes at 0xFE and 0xFF only; then DONE, ovf=1, count=2.
REQ-037 finish with 2 entries queued -> busy held through 2 writes, then done=1; a repeat run with rst asserted in DRAIN -> imem_we=0 next cycle and state IDLE.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes assembler fields into 32-bit words, buffers them and writes them to sequential imem addresses.
// Word lands on imem one cycle after acceptance; in_ready drops when the buffer is full. Optional macro: ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               finish,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         mnem,
    input  logic [3:0]         rd,
    input  logic [3:0]         rn,
    input  logic [3:0]         rm,
    input  logic signed [11:0] imm,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [31:0]        imem_wdata,
    input  logic               imem_ready,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic               err_illegal,
    output logic               err_range,
    output logic [ADDR_W:0]    count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr, r_rd;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf, r_err_illegal;

    logic [3:0]  w_op, w_rd, w_rn, w_rm;
    logic [11:0] w_imm12;
    logic [31:0] w_word;
    logic        w_legal, w_short, w_range_bad;
    logic        w_empty, w_full, w_busy, w_fire, w_push;
    logic        w_wr_done, w_last, w_start, w_flush;

    always_comb begin
        w_op    = 4'b0000;
        w_rd    = rd;
        w_rn    = rn;
        w_rm    = rm;
        w_imm12 = 12'd0;
        w_legal = 1'b1;
        w_short = 1'b0;
        case (mnem)
            4'd0: w_op = 4'b0000;
            4'd1: w_op = 4'b0001;
            4'd2: begin w_op = 4'b0010; w_rm = 4'd0; w_imm12 = imm[11:0]; end
            4'd3: begin w_op = 4'b0011; w_rm = 4'd0; w_imm12 = imm[11:0]; end
            4'd4: w_op = 4'b0100;
            4'd5: begin
                w_op    = 4'b0110;
                w_rm    = 4'd0;
                w_imm12 = {{4{imm[7]}}, imm[7:0]};
                w_short = 1'b1;
            end
            4'd6: begin
                w_op    = 4'b1000;
                w_rd    = 4'd0;
                w_rn    = 4'd0;
                w_rm    = 4'd0;
                w_imm12 = {{4{imm[7]}}, imm[7:0]};
                w_short = 1'b1;
            end
            4'd7: w_op = 4'b1001;
            default: w_legal = 1'b0;
        endcase
        w_word = {w_op, w_rd, w_rn, w_rm, 4'b0000, w_imm12};
    end

`ifdef ENC_RANGE_CHECK_EN
    // Short immediates must be representable in 8 signed bits: imm[11:7] all equal.
    assign w_range_bad = w_short && !((&imm[11:7]) || ~(|imm[11:7]));
`else
    assign w_range_bad = 1'b0;
`endif

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
    assign w_busy    = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign in_ready  = (r_state == S_LOAD) && !w_full;
    assign w_fire    = in_valid && in_ready;
    assign w_push    = w_fire && w_legal && !w_range_bad;
    assign imem_we   = w_busy && !w_empty;
    assign w_wr_done = imem_we && imem_ready;
    assign w_last    = w_wr_done && (r_ptr == '1);
    assign w_start   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_flush   = w_start || w_last;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= w_word;
    end

    // Flush on a new program or on address overflow discards whatever is queued.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push)    r_wr <= r_wr + 1'b1;
            if (w_wr_done) r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_LOAD;
            S_LOAD: begin
                if (w_last)      w_next = S_DONE;
                else if (finish) w_next = S_DRAIN;
            end
            S_DRAIN: if (w_last || w_empty) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= '0;
            r_count       <= '0;
            r_ovf         <= 1'b0;
            r_err_illegal <= 1'b0;
        end else if (w_start) begin
            r_ptr         <= base_addr;
            r_count       <= '0;
            r_ovf         <= 1'b0;
            r_err_illegal <= 1'b0;
        end else begin
            if (w_wr_done) begin
                r_count <= r_count + 1'b1;
                if (r_ptr != '1) r_ptr <= r_ptr + 1'b1;
            end
            if (w_last)              r_ovf         <= 1'b1;
            if (w_fire && !w_legal)  r_err_illegal <= 1'b1;
        end
    end

`ifdef ENC_RANGE_CHECK_EN
    logic r_err_range;
    always_ff @(posedge clk) begin
        if (rst || w_start)            r_err_range <= 1'b0;
        else if (w_fire && w_range_bad) r_err_range <= 1'b1;
    end
    assign err_range = r_err_range;
`else
    assign err_range = 1'b0;
`endif

    assign imem_addr   = r_ptr;
    assign imem_wdata  = imem_we ? r_mem[r_rd[AW-1:0]] : 32'd0;
    assign busy        = w_busy;
    assign done        = (r_state == S_DONE);
    assign ovf         = r_ovf;
    assign err_illegal = r_err_illegal;
    assign count       = r_count;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (default ADDR_W=8, FIFO_DEPTH=4).
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst, start, finish, in_valid, imem_ready;
    logic [7:0]  base_addr;
    logic [3:0]  mnem, rd, rn, rm;
    logic [11:0] imm;
    logic        in_ready, imem_we, busy, done, ovf, err_illegal, err_range;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  count;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem), .rd(rd), .rn(rn), .rm(rm),
        .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ready(imem_ready), .busy(busy), .done(done), .ovf(ovf),
        .err_illegal(err_illegal), .err_range(err_range), .count(count)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] m, input logic [3:0] d, input logic [3:0] n,
                             input logic [3:0] r, input logic [11:0] i);
        mnem = m; rd = d; rn = n; rm = r; imm = i;
    endtask

    task automatic do_start(input logic [7:0] a);
        start = 1'b1; base_addr = a;
        cyc();
        start = 1'b0;
    endtask

    task automatic close_run;
        finish = 1'b1;
        cyc();
        finish = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
        base_addr = 8'h00; set_instr(4'd0, 4'd0, 4'd0, 4'd0, 12'd0);
        cyc(); cyc();
        n_checks++;
        if ({imem_we, in_ready, busy, done, ovf, err_illegal, err_range} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000000",
                {imem_we, in_ready, busy, done, ovf, err_illegal, err_range});
        end
        n_checks++;
        if (imem_addr !== 8'h00 || imem_wdata !== 32'h0 || count !== 9'd0) begin
            n_fail++; $display("FAIL reset_values: addr %h data %h count %0d want 0/0/0",
                imem_addr, imem_wdata, count);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic;
        imem_ready = 1'b1;
        do_start(8'h10);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || imem_we !== 1'b0) begin
            n_fail++; $display("FAIL basic_load: busy %b in_ready %b we %b want 1 1 0", busy, in_ready, imem_we);
        end
        set_instr(4'd4, 4'd1, 4'd2, 4'd3, 12'h000); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h10 || imem_wdata !== 32'h41230000) begin
            n_fail++; $display("FAIL basic_write: we %b addr %h data %h want 1 10 41230000", imem_we, imem_addr, imem_wdata);
        end
        cyc();
        n_checks++;
        if (count !== 9'd1 || imem_we !== 1'b0 || imem_addr !== 8'h11) begin
            n_fail++; $display("FAIL basic_count: count %0d we %b addr %h want 1 0 11", count, imem_we, imem_addr);
        end
    endtask

    task automatic test_addi;
        set_instr(4'd5, 4'd4, 4'd4, 4'd9, 12'hFFE); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h11 || imem_wdata !== 32'h64400FFE) begin
            n_fail++; $display("FAIL addi_neg: we %b addr %h data %h want 1 11 64400ffe", imem_we, imem_addr, imem_wdata);
        end
        cyc();
        set_instr(4'd5, 4'd4, 4'd4, 4'd0, 12'h080); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        n_checks++;
        if (imem_we !== 1'b0 || err_range !== 1'b1) begin
            n_fail++; $display("FAIL addi_range: we %b err_range %b want 0 1", imem_we, err_range);
        end
`else
        n_checks++;
        if (imem_we !== 1'b1 || imem_wdata !== 32'h64400F80 || err_range !== 1'b0) begin
            n_fail++; $display("FAIL addi_trunc: we %b data %h err_range %b want 1 64400f80 0", imem_we, imem_wdata, err_range);
        end
`endif
        cyc();
        close_run();
        n_checks++;
`ifdef ENC_RANGE_CHECK_EN
        if (done !== 1'b1 || busy !== 1'b0 || count !== 9'd2) begin
`else
        if (done !== 1'b1 || busy !== 1'b0 || count !== 9'd3) begin
`endif
            n_fail++; $display("FAIL addi_done: done %b busy %b count %0d", done, busy, count);
        end
    endtask

    task automatic test_stall;
        int acc;
        logic rdy_s;
        logic [31:0] exp_w;
        do_start(8'h20);
        n_checks++;
        if (count !== 9'd0 || err_range !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL stall_restart: count %0d err_range %b done %b want 0 0 0", count, err_range, done);
        end
        imem_ready = 1'b0; acc = 0;
        for (int c = 0; c < 8; c++) begin
            set_instr(4'd4, acc[3:0], 4'd0, 4'd0, 12'd0); in_valid = 1'b1;
            #1; rdy_s = in_ready;
            cyc();
            if (rdy_s) acc++;
        end
        n_checks++;
        if (acc !== 4 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_accepts: accepted %0d in_ready %b want 4 0", acc, in_ready);
        end
        n_checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h20 || imem_wdata !== 32'h40000000) begin
            n_fail++; $display("FAIL stall_hold: we %b addr %h data %h want 1 20 40000000", imem_we, imem_addr, imem_wdata);
        end
        imem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            set_instr(4'd4, acc[3:0], 4'd0, 4'd0, 12'd0); in_valid = (acc < 6);
            #1;
            exp_w = {4'h4, 4'(c), 24'h0};
            n_checks++;
            if (imem_we !== 1'b1 || imem_addr !== 8'(8'h20 + c) || imem_wdata !== exp_w) begin
                n_fail++; $display("FAIL stall_write%0d: we %b addr %h data %h want 1 %h %h",
                    c, imem_we, imem_addr, imem_wdata, 8'(8'h20 + c), exp_w);
            end
            if (c == 0) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL stall_no_bypass: in_ready %b want 0", in_ready);
                end
            end
            rdy_s = in_ready && in_valid;
            cyc();
            if (rdy_s) acc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc !== 6 || count !== 9'd6 || imem_we !== 1'b0) begin
            n_fail++; $display("FAIL stall_total: accepted %0d count %0d we %b want 6 6 0", acc, count, imem_we);
        end
        close_run();
    endtask

    task automatic test_illegal;
        do_start(8'h40);
        imem_ready = 1'b1;
        set_instr(4'hA, 4'd1, 4'd2, 4'd3, 12'd0); in_valid = 1'b1;
        cyc();
        set_instr(4'd2, 4'd1, 4'd0, 4'd5, 12'h123);
        n_checks++;
        if (err_illegal !== 1'b1 || imem_we !== 1'b0) begin
            n_fail++; $display("FAIL illegal_flag: err_illegal %b we %b want 1 0", err_illegal, imem_we);
        end
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h40 || imem_wdata !== 32'h21000123) begin
            n_fail++; $display("FAIL illegal_ldr: we %b addr %h data %h want 1 40 21000123", imem_we, imem_addr, imem_wdata);
        end
        cyc();
        n_checks++;
        if (imem_we !== 1'b0 || count !== 9'd1 || err_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_single: we %b count %0d err_illegal %b want 0 1 1", imem_we, count, err_illegal);
        end
        close_run();
    endtask

    task automatic test_ovf;
        do_start(8'hFE);
        n_checks++;
        if (err_illegal !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: err_illegal %b want 0", err_illegal);
        end
        imem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_instr(4'd4, 4'(k + 1), 4'd0, 4'd0, 12'd0); in_valid = 1'b1;
            if (k > 0) begin
                n_checks++;
                if (imem_we !== 1'b1 || imem_addr !== 8'(8'hFD + k) || imem_wdata !== {4'h4, 4'(k), 24'h0}) begin
                    n_fail++; $display("FAIL ovf_write%0d: we %b addr %h data %h", k, imem_we, imem_addr, imem_wdata);
                end
            end
            cyc();
        end
        in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || ovf !== 1'b1 || count !== 9'd2 || imem_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ovf_end: done %b ovf %b count %0d we %b busy %b want 1 1 2 0 0",
                done, ovf, count, imem_we, busy);
        end
    endtask

    task automatic test_drain;
        do_start(8'h50);
        imem_ready = 1'b0;
        set_instr(4'd0, 4'd1, 4'd2, 4'd3, 12'h5A5); in_valid = 1'b1;
        cyc();
        set_instr(4'd6, 4'd5, 4'd6, 4'd7, 12'hF85);
        cyc();
        in_valid = 1'b0; finish = 1'b1;
        cyc();
        finish = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || imem_we !== 1'b1 || imem_addr !== 8'h50 || imem_wdata !== 32'h01230000) begin
            n_fail++; $display("FAIL drain_w0: busy %b we %b addr %h data %h want 1 1 50 01230000", busy, imem_we, imem_addr, imem_wdata);
        end
        imem_ready = 1'b1;
        cyc();
        n_checks++;
        if (busy !== 1'b1 || imem_we !== 1'b1 || imem_addr !== 8'h51 || imem_wdata !== 32'h80000F85) begin
            n_fail++; $display("FAIL drain_w1: busy %b we %b addr %h data %h want 1 1 51 80000f85", busy, imem_we, imem_addr, imem_wdata);
        end
        cyc();
        n_checks++;
        if (busy !== 1'b1 || imem_we !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: busy %b we %b done %b want 1 0 0", busy, imem_we, done);
        end
        cyc();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 9'd2) begin
            n_fail++; $display("FAIL drain_done: done %b busy %b count %0d want 1 0 2", done, busy, count);
        end
        do_start(8'h60);
        imem_ready = 1'b0;
        set_instr(4'd1, 4'd2, 4'd3, 4'd4, 12'd0); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0; finish = 1'b1;
        cyc();
        finish = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || imem_we !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_pre: busy %b we %b in_ready %b want 1 1 0", busy, imem_we, in_ready);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if (imem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 9'd0 || imem_addr !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid: we %b busy %b done %b count %0d addr %h want 0 0 0 0 00",
                imem_we, busy, done, count, imem_addr);
        end
        start = 1'b1; finish = 1'b1; base_addr = 8'h70;
        cyc();
        start = 1'b0; finish = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || imem_addr !== 8'h70) begin
            n_fail++; $display("FAIL start_wins: busy %b in_ready %b addr %h want 1 1 70", busy, in_ready, imem_addr);
        end
        close_run();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_addi();
        test_stall();
        test_illegal();
        test_ovf();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
